// File: rtl/aes_io_ctrl.sv
// Byte-serial front/back end for the 2-share AES core: masks plaintext, streams shares+key, gathers ciphertext shares.
// Latency: 16 load cycles after accept; OutValidxSO rises 16 cycles after the core's first DonexSI in WAIT.
// Backpressure: one job in flight; InReadyxSO only in IDLE; ciphertext held while OutReadyxSI is low.
// Option: define AES_IO_UNMASK_EN to return the recombined ciphertext on CtxDO0 (CtxDO1 = 0).
module aes_io_ctrl (
  input  logic         ClkxCI,
  input  logic         RstxBI,
  input  logic         InValidxSI,
  output logic         InReadyxSO,
  input  logic [127:0] PtxDI,
  input  logic [127:0] KeyxDI,
  input  logic [127:0] RndxDI,
  output logic         OutValidxSO,
  input  logic         OutReadyxSI,
  output logic [127:0] CtxDO0,
  output logic [127:0] CtxDO1,
  output logic         BusyxSO,
  output logic         StartxSO,
  output logic [7:0]   PTxDO0,
  output logic [7:0]   PTxDO1,
  output logic [7:0]   KxDO,
  input  logic         DonexSI,
  input  logic [7:0]   CxDI0,
  input  logic [7:0]   CxDI1
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_WAIT,
    S_COLLECT,
    S_OUT
  } state_t;

  state_t         state_q, state_d;
  logic [3:0]     cnt_q, cnt_d;
  logic           start_q, start_d;
  logic [127:0]   sh0_q, sh0_d;
  logic [127:0]   sh1_q, sh1_d;
  logic [127:0]   kr_q, kr_d;
  logic [127:0]   cr0_q, cr0_d;
  logic [127:0]   cr1_q, cr1_d;
  logic [127:0]   cr0_shift, cr1_shift;

  // Ciphertext bytes arrive MSB-first, so each new byte enters at the bottom.
  assign cr0_shift = {cr0_q[119:0], CxDI0};
  assign cr1_shift = {cr1_q[119:0], CxDI1};

  // Next-state and datapath update; every register holds unless its state says otherwise.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    start_d = 1'b0;
    sh0_d   = sh0_q;
    sh1_d   = sh1_q;
    kr_d    = kr_q;
    cr0_d   = cr0_q;
    cr1_d   = cr1_q;
    case (state_q)
      S_IDLE: begin
        if (InValidxSI) begin
          // Only the two shares are kept; the bare plaintext never reaches a flop.
          sh0_d   = RndxDI;
          sh1_d   = PtxDI ^ RndxDI;
          kr_d    = KeyxDI;
          cnt_d   = 4'd0;
          start_d = 1'b1;
          state_d = S_LOAD;
        end
      end
      S_LOAD: begin
        // Zero-fill leaves the shift registers clear once all 16 bytes are out,
        // which keeps the core byte outputs at zero outside LOAD.
        sh0_d = {sh0_q[119:0], 8'h00};
        sh1_d = {sh1_q[119:0], 8'h00};
        kr_d  = {kr_q[119:0], 8'h00};
        cnt_d = cnt_q + 4'd1;
        if (cnt_q == 4'd15) begin
          state_d = S_WAIT;
        end
      end
      S_WAIT: begin
        if (DonexSI) begin
          cr0_d   = cr0_shift;
          cr1_d   = cr1_shift;
          cnt_d   = 4'd1;
          state_d = S_COLLECT;
        end
      end
      S_COLLECT: begin
        cr0_d = cr0_shift;
        cr1_d = cr1_shift;
        cnt_d = cnt_q + 4'd1;
        if (cnt_q == 4'd15) begin
`ifdef AES_IO_UNMASK_EN
          // Shares are combined into a register on the way into OUT.
          cr0_d = cr0_shift ^ cr1_shift;
          cr1_d = '0;
`endif
          state_d = S_OUT;
        end
      end
      S_OUT: begin
        if (OutReadyxSI) begin
          cr0_d   = '0;
          cr1_d   = '0;
          state_d = S_IDLE;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State and data registers with synchronous active-low reset.
  always_ff @(posedge ClkxCI) begin
    if (!RstxBI) begin
      state_q <= S_IDLE;
      cnt_q   <= 4'd0;
      start_q <= 1'b0;
      sh0_q   <= '0;
      sh1_q   <= '0;
      kr_q    <= '0;
      cr0_q   <= '0;
      cr1_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      start_q <= start_d;
      sh0_q   <= sh0_d;
      sh1_q   <= sh1_d;
      kr_q    <= kr_d;
      cr0_q   <= cr0_d;
      cr1_q   <= cr1_d;
    end
  end

  assign InReadyxSO  = (state_q == S_IDLE);
  assign BusyxSO     = (state_q != S_IDLE);
  assign OutValidxSO = (state_q == S_OUT);
  assign StartxSO    = start_q;
  assign PTxDO0      = sh0_q[127:120];
  assign PTxDO1      = sh1_q[127:120];
  assign KxDO        = kr_q[127:120];
  assign CtxDO0      = cr0_q;
  assign CtxDO1      = cr1_q;

endmodule

// File: doc/aes_io_ctrl.md
# aes_io_ctrl

Byte-serial I/O controller placed directly in front of and behind the 2-share AES encryption core. It accepts a 128-bit plaintext and key over a valid/ready handshake and masks the plaintext with 128 fresh random bits. It streams the plaintext shares and the key into the core one byte per cycle, pulses the core start, then collects the 16 ciphertext share bytes the core emits after its done flag. It returns the ciphertext over a second valid/ready handshake.

## Interface
- Parameters: none.
- ClkxCI  in  1  clock; all logic on the rising edge.
- RstxBI  in  1  reset, synchronous, active-low.
- InValidxSI  in  1  plaintext/key/random valid.
- InReadyxSO  out  1  block can accept a job.
- PtxDI  in  128  plaintext; byte 0 = bits [127:120], FIPS-197 order.
- KeyxDI  in  128  cipher key, same byte order.
- RndxDI  in  128  fresh random bits, used only on the accept cycle.
- OutValidxSO  out  1  ciphertext valid.
- OutReadyxSI  in  1  consumer takes ciphertext.
- CtxDO0  out  128  ciphertext share 0 (unmasked ciphertext when AES_IO_UNMASK_EN).
- CtxDO1  out  128  ciphertext share 1 (zero when AES_IO_UNMASK_EN).
- BusyxSO  out  1  high in every state except IDLE.
- StartxSO  out  1  core start pulse.
- PTxDO0  out  8  plaintext share-0 byte to the core.
- PTxDO1  out  8  plaintext share-1 byte to the core.
- KxDO  out  8  key byte to the core.
- DonexSI  in  1  core: first ciphertext byte on CxDI0/1 this cycle.
- CxDI0  in  8  core ciphertext share 0.
- CxDI1  in  8  core ciphertext share 1.

## Operation
- The FSM has five states: IDLE, LOAD, WAIT, COLLECT, OUT. A 4-bit byte counter runs in LOAD and COLLECT.
- IDLE:
  - InReadyxSO = 1.
  - On InValidxSI & InReadyxSO: Sh0 ← RndxDI, Sh1 ← PtxDI ^ RndxDI, Kr ← KeyxDI, counter ← 0, go to LOAD.
  - The unmasked plaintext is never stored.
- LOAD, 16 cycles:
  - PTxDO0/PTxDO1/KxDO = bits [127:120] of Sh0/Sh1/Kr, driven directly from registers with no combinational logic after the flops.
  - Each cycle, Sh0/Sh1/Kr shift left by 8 and zero-fill.
  - StartxSO = 1 only in the first LOAD cycle (counter = 0).
  - When counter = 15, go to WAIT.
- WAIT:
  - PTxDO0/PTxDO1/KxDO = 0.
  - On DonexSI = 1: capture byte 0, counter ← 1, go to COLLECT.
- COLLECT:
  - Every cycle, including the Done cycle: Cr0 ← {Cr0[119:0], CxDI0} and Cr1 ← {Cr1[119:0], CxDI1}.
  - After the 16th byte (counter = 15 captured), go to OUT.
  - DonexSI is ignored in COLLECT.
- OUT:
  - OutValidxSO = 1.
  - CtxDO0/CtxDO1 hold steady while OutValidxSO = 1 and OutReadyxSI = 0.
  - On OutReadyxSI = 1: clear Cr0/Cr1, go to IDLE.
- DonexSI outside WAIT is ignored, with no state change.
- InValidxSI outside IDLE is ignored; InReadyxSO = 0 there.

## Timing
- Reset: all outputs 0 except InReadyxSO = 1; state IDLE; all data registers 0.
- Reset low in any state aborts the job at the next edge. No StartxSO is issued after reset, and no stale data appears on the outputs.
- Accept edge at cycle t. LOAD occupies cycles t+1 … t+16. StartxSO is high in cycle t+1, together with byte 0. Byte k is presented in cycle t+1+k.
- If DonexSI is first seen high in cycle d, then ciphertext bytes 0…15 are sampled in cycles d … d+15. OutValidxSO rises in cycle d+16.
- In OUT with OutReadyxSI = 1 in cycle o: OutValidxSO = 0 and InReadyxSO = 1 in cycle o+1. A new job can be accepted in cycle o+1.
- DonexSI asserted in the last LOAD cycle is ignored, because the state is not yet WAIT.
- Throughput limit: one job in flight.

## Configuration
- AES_IO_UNMASK_EN defined:
  - On the OUT transition, CtxDO0 = Cr0 ^ Cr1 (the unmasked ciphertext) and CtxDO1 = 0.
  - The XOR is registered. OUT timing is unchanged.
- AES_IO_UNMASK_EN undefined:
  - CtxDO0 = Cr0 and CtxDO1 = Cr1; the shares are exported and never combined.

## Test plan
- Reset, then idle: all outputs 0 and InReadyxSO = 1. Assert reset during LOAD → next cycle IDLE, StartxSO = 0, PTxDO0/PTxDO1/KxDO = 0.
- Load check:
  - Stimulus: PtxDI = 00112233445566778899aabbccddeeff, KeyxDI = 000102030405060708090a0b0c0d0e0f, RndxDI = a5a5…a5.
  - Required: StartxSO high for exactly 1 cycle. Byte k gives PTxDO0 = a5, PTxDO1 = PT[k] ^ a5, KxDO = k. Byte 0 gives PTxDO1 = a5.
- End-to-end with the real core on the same vector, twice, with RndxDI = 0 and with random RndxDI:
  - With AES_IO_UNMASK_EN: CtxDO0 = 69c4e0d86a7b0430d8cdb78070b4c55a.
  - Without AES_IO_UNMASK_EN: CtxDO0 ^ CtxDO1 equals that value.
- Backpressure: hold OutReadyxSI = 0 for 20 cycles → OutValidxSO and CtxDO0/CtxDO1 stable for all 20 cycles. InValidxSI = 1 throughout → no accept until the cycle after OutReadyxSI = 1.
- Spurious done: pulse DonexSI in IDLE and during LOAD → no state change and OutValidxSO stays 0. A later genuine DonexSI in WAIT gives a correct ciphertext.
- Back-to-back jobs: second InValidxSI already high when OUT completes → accepted in cycle o+1, and the second ciphertext is correct.
